avr_mem_arb: RTL

- Memory controller that replaces the separate ROM/RAM ports with one shared, byte-wide, synchronous external SRAM.
- Serves CPU instruction fetches (16-bit, two byte accesses) and data reads/writes (8-bit) through a req/ready handshake.
- Provides configurable wait states and round-robin arbitration.
- Sits between avrcpu and the board/simulation memory.

---
 rtl/avr_mem_pkg.sv | 11 +
 rtl/avr_mem_phase.sv | 27 ++
 rtl/avr_mem_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/avr_mem_pkg.sv
// avr_mem_pkg: controller states, grant encoding and default geometry for avr_mem_arb.
package avr_mem_pkg;
    typedef enum logic [2:0] {IDLE, F_LO, F_HI, D_RD, D_WR, PF_LO, PF_HI} state_t;
    typedef enum logic {FETCH, DATA} grant_t;
    localparam int          PC_W_DEF      = 16;
    localparam int          DA_W_DEF      = 16;
    localparam int          M_W_DEF       = 17;
    localparam int          WAIT_DEF      = 0;
    localparam logic [16:0] PROG_BASE_DEF = 17'h00000;
    localparam logic [16:0] DATA_BASE_DEF = 17'h10000;
endpackage

// File: rtl/avr_mem_phase.sv
// avr_mem_phase: byte-access timer; a phase spans 2+wait cycles from i_start,
// o_we_win covers its final cycle and o_cap marks the edge that closes it.
module avr_mem_phase (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [3:0] i_wait,
    output logic       o_cap,
    output logic       o_we_win
);
    logic       r_act;
    logic [4:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_act <= 1'b1;
            r_cnt <= {1'b0, i_wait} + 5'd1;
        end else if (r_act) begin
            if (r_cnt == 5'd0) r_act <= 1'b0;
            else r_cnt <= r_cnt - 5'd1;
        end
    end
    assign o_we_win = r_act & (r_cnt == 5'd0);
    assign o_cap    = o_we_win;
endmodule

// File: rtl/avr_mem_arb.sv
// avr_mem_arb: round-robin fetch/data arbiter onto one byte-wide synchronous SRAM.
// Define AVR_MEM_PF_EN to add a one-word instruction prefetch buffer.
module avr_mem_arb
    import avr_mem_pkg::*;
#(
    parameter int             PC_W      = PC_W_DEF,
    parameter int             DA_W      = DA_W_DEF,
    parameter int             M_W       = M_W_DEF,
    parameter int             WAIT      = WAIT_DEF,
    parameter logic [M_W-1:0] PROG_BASE = M_W'(PROG_BASE_DEF),
    parameter logic [M_W-1:0] DATA_BASE = M_W'(DATA_BASE_DEF)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_req,
    input  logic [PC_W-1:0] pc,
    output logic            i_ready,
    output logic [15:0]     ir,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DA_W-1:0] d_addr,
    input  logic [7:0]      d_wdata,
    output logic            d_ready,
    output logic [7:0]      d_rdata,
    output logic [M_W-1:0]  m_addr,
    output logic [7:0]      m_wdata,
    output logic            m_we,
    input  logic [7:0]      m_rdata
);
    state_t         r_state, w_next;
    grant_t         r_last;
    logic           r_i_ready, r_d_ready;
    logic [15:0]    r_ir;
    logic [7:0]     r_lo, r_d_rdata, r_m_wdata;
    logic [M_W-1:0] r_m_addr, w_addr_n, w_f_addr, w_d_addr, w_pf_addr;
    logic           w_start, w_cap, w_we_win, w_gnt, w_block, w_any, w_pick_d;
    logic           w_f_done, w_hit, w_pf_go;
    logic [15:0]    w_pf_word;
    avr_mem_phase u_phase (
        .clk      (clock),
        .rst      (reset),
        .i_start  (w_start),
        .i_wait   (4'(WAIT)),
        .o_cap    (w_cap),
        .o_we_win (w_we_win)
    );
    // The cycle right after a ready pulse is blocked so a still-high req is not served twice.
    assign w_block  = r_i_ready | r_d_ready;
    assign w_any    = i_req | d_req;
    assign w_pick_d = d_req & (~i_req | (r_last == FETCH));
    assign w_f_addr = PROG_BASE + M_W'({pc, 1'b0});
    assign w_d_addr = DATA_BASE + M_W'(d_addr);
    assign w_f_done = (r_state == F_HI) & w_cap;
`ifdef AVR_MEM_PF_EN
    logic            r_pf_valid, r_pf_pend, w_wr_hit;
    logic [PC_W-1:0] r_pf_tag;
    logic [15:0]     r_pf_word;
    assign w_pf_addr = PROG_BASE + M_W'({r_pf_tag, 1'b0});
    assign w_hit     = ~w_pick_d & r_pf_valid & (pc == r_pf_tag);
    assign w_pf_go   = ~w_any & r_pf_pend;
    assign w_pf_word = r_pf_word;
    assign w_wr_hit  = w_gnt & w_pick_d & d_we & ((w_d_addr == w_pf_addr) | (w_d_addr == w_pf_addr + 1'b1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b0;
            r_pf_tag   <= '0;
            r_pf_word  <= '0;
        end else begin
            if (w_f_done) begin
                r_pf_pend <= 1'b1;
                r_pf_tag  <= pc + 1'b1;
            end else if ((r_state == IDLE) & w_pf_go) r_pf_pend <= 1'b0;
            if ((r_state == PF_HI) & w_cap) r_pf_word <= {m_rdata, r_lo};
            if (w_f_done | w_wr_hit) r_pf_valid <= 1'b0;
            else if ((r_state == PF_HI) & w_cap) r_pf_valid <= 1'b1;
        end
    end
`else
    assign w_pf_addr = '0;
    assign w_hit     = 1'b0;
    assign w_pf_go   = 1'b0;
    assign w_pf_word = 16'h0000;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_gnt    = 1'b0;
        w_addr_n = r_m_addr;
        case (r_state)
            IDLE: begin
                if (~w_block & w_any) begin
                    w_gnt    = 1'b1;
                    w_start  = ~w_hit;
                    w_next   = w_pick_d ? (d_we ? D_WR : D_RD) : (w_hit ? IDLE : F_LO);
                    w_addr_n = w_pick_d ? w_d_addr : (w_hit ? r_m_addr : w_f_addr);
                end else if (w_pf_go) begin
                    w_start  = 1'b1;
                    w_next   = PF_LO;
                    w_addr_n = w_pf_addr;
                end
            end
            F_LO, PF_LO: if (w_cap) begin
                w_start  = 1'b1;
                w_next   = (r_state == F_LO) ? F_HI : PF_HI;
                w_addr_n = r_m_addr + 1'b1;
            end
            default: if (w_cap) w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last    <= FETCH;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_ir      <= 16'h0000;
            r_lo      <= '0;
            r_d_rdata <= '0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_m_addr  <= w_addr_n;
            r_i_ready <= w_f_done | (w_gnt & w_hit);
            r_d_ready <= ((r_state == D_RD) | (r_state == D_WR)) & w_cap;
            if (w_gnt) r_last <= w_pick_d ? DATA : FETCH;
            if (w_gnt & w_pick_d & d_we) r_m_wdata <= d_wdata;
            if (((r_state == F_LO) | (r_state == PF_LO)) & w_cap) r_lo <= m_rdata;
            if (w_f_done) r_ir <= {m_rdata, r_lo};
            else if (w_gnt & w_hit) r_ir <= w_pf_word;
            if ((r_state == D_RD) & w_cap) r_d_rdata <= m_rdata;
        end
    end
    assign i_ready = r_i_ready;
    assign d_ready = r_d_ready;
    assign ir      = r_ir;
    assign d_rdata = r_d_rdata;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_we    = (r_state == D_WR) & w_we_win;
endmodule
